// File: rtl/accel_settings_bank.sv
// Settings register bank: ID/version, free-running counter, scratch, per-stream AXI user/cache attributes, soft-reset pulse.
// Optional ACCEL_SETTINGS_COUNTER64_EN widens the counter to 64 bits with a high-word read shadow.
module accel_settings_bank #(
    parameter int C_DATAWIDTH    = 32,
    parameter int C_ADDRWIDTH    = 32,
    parameter int C_PAGEWIDTH    = 12,
    parameter int C_NUM_STREAMS  = 4,
    parameter int C_RESET_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [C_DATAWIDTH-1:0]       set_data,
    input  logic                         set_stb,
    input  logic [C_ADDRWIDTH-1:0]       set_addr,
    input  logic                         get_stb,
    input  logic [C_ADDRWIDTH-1:0]       get_addr,
    output logic [C_DATAWIDTH-1:0]       get_data,
    output logic                         get_ack,
    output logic                         soft_reset,
    output logic [5*C_NUM_STREAMS-1:0]   aruser,
    output logic [5*C_NUM_STREAMS-1:0]   awuser,
    output logic [4*C_NUM_STREAMS-1:0]   arcache,
    output logic [4*C_NUM_STREAMS-1:0]   awcache
);
    localparam int          IW  = C_PAGEWIDTH - 2;
    localparam logic [31:0] SIG = 32'hACE0BA54;
    localparam logic [31:0] BAD = 32'h01234567;
`ifdef ACCEL_SETTINGS_COUNTER64_EN
    localparam int CW = 64;
`else
    localparam int CW = 32;
`endif

    typedef enum logic {IDLE, ASSERT} state_t;

    logic [IW-1:0] set_idx, get_idx;
    logic [C_NUM_STREAMS-1:0][4:0] aruser_r, awuser_r;
    logic [C_NUM_STREAMS-1:0][3:0] arcache_r, awcache_r;
    logic [31:0]   scratch;
    logic [CW-1:0] cnt;
    logic [31:0]   rd_word;
    state_t        state;
    logic [7:0]    rem;
    logic          wr_sig;

    assign set_idx = set_addr[C_PAGEWIDTH-1:2];
    assign get_idx = get_addr[C_PAGEWIDTH-1:2];
    assign wr_sig  = set_stb && (set_idx == IW'(0));

    assign aruser  = aruser_r;
    assign awuser  = awuser_r;
    assign arcache = arcache_r;
    assign awcache = awcache_r;

    // Stream i owns words 8+4i .. 11+4i: aruser, arcache, awuser, awcache.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aruser_r  <= '1;
            awuser_r  <= '1;
            arcache_r <= '1;
            awcache_r <= '1;
            scratch   <= '0;
        end else if (set_stb) begin
            if (set_idx == IW'(4)) scratch <= set_data[31:0];
            for (int i = 0; i < C_NUM_STREAMS; i++) begin
                if (set_idx == IW'(8 + 4*i))  aruser_r[i]  <= set_data[4:0];
                if (set_idx == IW'(9 + 4*i))  arcache_r[i] <= set_data[3:0];
                if (set_idx == IW'(10 + 4*i)) awuser_r[i]  <= set_data[4:0];
                if (set_idx == IW'(11 + 4*i)) awcache_r[i] <= set_data[3:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else     cnt <= cnt + 1'b1;
    end

`ifdef ACCEL_SETTINGS_COUNTER64_EN
    logic [31:0] shadow;
    // Latching the high word on the low-word read keeps a {hi,lo} pair coherent across a carry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                  shadow <= '0;
        else if (get_stb && get_idx == IW'(2))    shadow <= cnt[63:32];
    end
`endif

    always_comb begin
        rd_word = BAD;
        if      (get_idx == IW'(0)) rd_word = SIG;
        else if (get_idx == IW'(1)) rd_word = {16'(C_NUM_STREAMS), 16'h0002};
        else if (get_idx == IW'(2)) rd_word = cnt[31:0];
`ifdef ACCEL_SETTINGS_COUNTER64_EN
        else if (get_idx == IW'(3)) rd_word = shadow;
`endif
        else if (get_idx == IW'(4)) rd_word = scratch;
        else begin
            for (int i = 0; i < C_NUM_STREAMS; i++) begin
                if (get_idx == IW'(8 + 4*i))  rd_word = {27'd0, aruser_r[i]};
                if (get_idx == IW'(9 + 4*i))  rd_word = {28'd0, arcache_r[i]};
                if (get_idx == IW'(10 + 4*i)) rd_word = {27'd0, awuser_r[i]};
                if (get_idx == IW'(11 + 4*i)) rd_word = {28'd0, awcache_r[i]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            get_data <= '0;
            get_ack  <= 1'b0;
        end else begin
            get_ack <= get_stb;
            if (get_stb) get_data <= rd_word;
        end
    end

    // Rewriting word 0 while asserted reloads the count, stretching the pulse without a gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            soft_reset <= 1'b0;
            rem        <= '0;
        end else begin
            case (state)
                IDLE: if (wr_sig) begin
                    state      <= ASSERT;
                    soft_reset <= 1'b1;
                    rem        <= 8'(C_RESET_CYCLES);
                end
                ASSERT: begin
                    if (wr_sig) rem <= 8'(C_RESET_CYCLES);
                    else if (rem == 8'd1) begin
                        state      <= IDLE;
                        soft_reset <= 1'b0;
                        rem        <= '0;
                    end else rem <= rem - 8'd1;
                end
                default: begin
                    state      <= IDLE;
                    soft_reset <= 1'b0;
                end
            endcase
        end
    end
endmodule
